// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that owns a shared WIDTH-bit register. One requester at a
// time holds a registered one-hot grant and writes its data into the register.
// A hold limit forces rotation when others are waiting.
module dff_bank_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    busy,
    output logic [WIDTH-1:0]        q,
    output logic                    q_valid,
    output logic                    preempt
);

    localparam int unsigned IdxW  = $clog2(NREQ);
    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              q_valid_q, q_valid_d;
    logic              preempt_q, preempt_d;

    logic [NREQ-1:0]   cand;
    logic              others;
    logic              at_limit;
    logic [IdxW-1:0]   next_ptr;
    logic [IdxW-1:0]   sel_base;
    logic [IdxW-1:0]   sel_idx;
    logic [NREQ-1:0]   sel_onehot;

    // First set bit of r scanning base, base+1, ... with wrap-around.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                                input logic [IdxW-1:0] base);
        logic [IdxW-1:0] res;
        logic [IdxW-1:0] cur;
        logic            found;
        int unsigned     idx;
        res   = base;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(base) + k) % NREQ;
            cur = IdxW'(idx);
            if (!found && r[cur]) begin
                found = 1'b1;
                res   = cur;
            end
        end
        return res;
    endfunction

    // Candidate selection: the current owner never competes for its own handover.
    always_comb begin
        cand       = req & ~gnt_q;
        others     = |cand;
        at_limit   = (32'(hold_q) + 32'd1) >= MAX_HOLD;
        next_ptr   = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        sel_base   = (state_q == StIdle) ? ptr_q : next_ptr;
        sel_idx    = rr_pick(cand, sel_base);
        sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
    end

    // Next-state logic for ownership, rr pointer, hold counter and shared register.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        preempt_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (others) begin
                    state_d = StOwn;
                    owner_d = sel_idx;
                    gnt_d   = sel_onehot;
                    hold_d  = '0;
                end
            end
            StOwn: begin
                if (req[owner_q]) begin
                    q_d       = wdata[32'(owner_q)*WIDTH +: WIDTH];
                    q_valid_d = 1'b1;
                    if (at_limit && others) begin
                        // Forced rotation: last write lands, ownership moves on.
                        ptr_d     = next_ptr;
                        owner_d   = sel_idx;
                        gnt_d     = sel_onehot;
                        hold_d    = '0;
                        preempt_d = 1'b1;
                    end else if (32'(hold_q) < MAX_HOLD) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else begin
                    ptr_d  = next_ptr;
                    hold_d = '0;
                    if (others) begin
                        owner_d = sel_idx;
                        gnt_d   = sel_onehot;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset overriding any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = (state_q == StOwn);
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign preempt = preempt_q;

endmodule
